// File: rtl/wb_pkg.sv
// Shared definitions for the writeback buffer: default widths and the entry record.
package wb_pkg;

  localparam int DATA_W_DEF = 19;
  localparam int ADDR_W_DEF = 5;

  // One buffered register-file write: destination register and its value.
  typedef struct packed {
    logic [ADDR_W_DEF-1:0] rd;
    logic [DATA_W_DEF-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Circular entry store for the writeback buffer: push at tail, pop at head,
// with per-entry valid flags and register numbers exposed for hazard lookup.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DEPTH  = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  logic                         pop,
  input  logic [ADDR_W-1:0]            push_rd,
  input  logic [DATA_W-1:0]            push_data,
  output logic [ADDR_W-1:0]            head_rd,
  output logic [DATA_W-1:0]            head_data,
  output logic [$clog2(DEPTH):0]       count,
  output logic [DEPTH-1:0]             ent_valid,
  output logic [DEPTH-1:0][ADDR_W-1:0] ent_rd
);

  localparam int PTR_W = $clog2(DEPTH);

  typedef struct packed {
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t             mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [DEPTH-1:0]   valid;

  // Pointers, occupancy and valid flags; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      valid  <= '0;
    end else begin
      if (push) begin
        wr_ptr        <= wr_ptr + 1'b1;
        valid[wr_ptr] <= 1'b1;
      end
      if (pop) begin
        rd_ptr        <= rd_ptr + 1'b1;
        valid[rd_ptr] <= 1'b0;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entry payload; no reset needed since valid flags gate every use.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{rd: push_rd, data: push_data};
  end

  assign head_rd   = mem[rd_ptr].rd;
  assign head_data = mem[rd_ptr].data;
  assign ent_valid = valid;

  for (genvar g = 0; g < DEPTH; g++) begin : g_ent
    assign ent_rd[g] = mem[g].rd;
  end

endmodule

// File: rtl/writeback_buffer.sv
// Writeback buffer: queues results in arrival order and drains them into the
// register-file write port, flagging source registers with pending writes.
module writeback_buffer
  import wb_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DEPTH  = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   res_valid,
  input  logic [ADDR_W-1:0]      res_rd,
  input  logic [DATA_W-1:0]      res_data,
  output logic                   res_ready,
  input  logic                   hold_wb,
  output logic [ADDR_W-1:0]      a3,
  output logic                   we3,
  output logic [DATA_W-1:0]      wd3,
  input  logic [ADDR_W-1:0]      q_a1,
  input  logic [ADDR_W-1:0]      q_a2,
  output logic                   pend1,
  output logic                   pend2,
  output logic [$clog2(DEPTH):0] count
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  logic                         push;
  logic                         pop;
  logic                         nonempty;
  logic [ADDR_W-1:0]            head_rd;
  logic [DATA_W-1:0]            head_data;
  logic [DEPTH-1:0]             ent_valid;
  logic [DEPTH-1:0][ADDR_W-1:0] ent_rd;

  wb_fifo #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .pop       (pop),
    .push_rd   (res_rd),
    .push_data (res_data),
    .head_rd   (head_rd),
    .head_data (head_data),
    .count     (count),
    .ent_valid (ent_valid),
    .ent_rd    (ent_rd)
  );

  // Ready depends on occupancy only; a full buffer never accepts, even while draining.
  assign nonempty  = (count != '0);
  assign res_ready = (count != FULL);
  assign push      = res_valid & res_ready;
  assign we3       = nonempty & ~hold_wb;
  assign pop       = we3;
  assign a3        = nonempty ? head_rd   : '0;
  assign wd3       = nonempty ? head_data : '0;

  // A source is pending while any live entry targets it, including the head being written.
  always_comb begin
    pend1 = 1'b0;
    pend2 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_valid[i] && (ent_rd[i] == q_a1)) pend1 = 1'b1;
      if (ent_valid[i] && (ent_rd[i] == q_a2)) pend2 = 1'b1;
    end
  end

endmodule

// File: tb/tb_writeback_buffer.sv
// Directed bench for writeback_buffer: table of per-cycle vectors plus
// hand-written sequences for wrap-around and mid-operation reset.
module tb_writeback_buffer;
  import wb_pkg::*;

  localparam int DW = 19;
  localparam int AW = 5;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          res_valid;
  logic [AW-1:0] res_rd;
  logic [DW-1:0] res_data;
  logic          res_ready;
  logic          hold_wb;
  logic [AW-1:0] a3;
  logic          we3;
  logic [DW-1:0] wd3;
  logic [AW-1:0] q_a1;
  logic [AW-1:0] q_a2;
  logic          pend1;
  logic          pend2;
  logic [2:0]    count;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] rf [32] = '{default: '0};
  int            wr_cnt = 0;

  always #5 clk = ~clk;

  writeback_buffer #(
    .DATA_W (DW),
    .ADDR_W (AW),
    .DEPTH  (DEPTH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .res_valid (res_valid),
    .res_rd    (res_rd),
    .res_data  (res_data),
    .res_ready (res_ready),
    .hold_wb   (hold_wb),
    .a3        (a3),
    .we3       (we3),
    .wd3       (wd3),
    .q_a1      (q_a1),
    .q_a2      (q_a2),
    .pend1     (pend1),
    .pend2     (pend2),
    .count     (count)
  );

  // Register-file model fed by the write port.
  always @(posedge clk) begin
    if (we3) begin
      rf[a3] <= wd3;
      wr_cnt <= wr_cnt + 1;
    end
  end

  typedef struct {
    logic          vld;
    wb_entry_t     res;
    logic          hold;
    logic [AW-1:0] q1;
    logic [AW-1:0] q2;
    logic          rdy;
    logic          we;
    logic [AW-1:0] a;
    logic [DW-1:0] wd;
    logic          p1;
    logic          p2;
    logic [2:0]    cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic vld, input logic [AW-1:0] rd, input logic [DW-1:0] d,
                              input logic hold, input logic [AW-1:0] q1, input logic [AW-1:0] q2,
                              input logic rdy, input logic we, input logic [AW-1:0] a,
                              input logic [DW-1:0] wd, input logic p1, input logic p2,
                              input logic [2:0] cnt);
    vec_t v;
    v.vld = vld; v.res.rd = rd; v.res.data = d; v.hold = hold; v.q1 = q1; v.q2 = q2;
    v.rdy = rdy; v.we = we; v.a = a; v.wd = wd; v.p1 = p1; v.p2 = p2; v.cnt = cnt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [AW-1:0] rd, input logic [DW-1:0] d,
                       input logic h, input logic [AW-1:0] a1, input logic [AW-1:0] a2);
    res_valid = v;
    res_rd    = rd;
    res_data  = d;
    hold_wb   = h;
    q_a1      = a1;
    q_a2      = a2;
  endtask

  task automatic expect_out(input string tag, input logic rdy, input logic we,
                            input logic [AW-1:0] a, input logic [DW-1:0] wd,
                            input logic p1, input logic p2, input logic [2:0] cnt);
    chk({tag, ".ready"}, 32'(res_ready), 32'(rdy));
    chk({tag, ".we3"},   32'(we3),       32'(we));
    chk({tag, ".a3"},    32'(a3),        32'(a));
    chk({tag, ".wd3"},   32'(wd3),       32'(wd));
    chk({tag, ".pend1"}, 32'(pend1),     32'(p1));
    chk({tag, ".pend2"}, 32'(pend2),     32'(p2));
    chk({tag, ".count"}, 32'(count),     32'(cnt));
  endtask

  initial begin
    int wc;

    // single result: push, written next edge, drained
    vecs.push_back(mk(1, 2, 'h4,   0, 2, 0, 1, 0, 0, 'h0,   0, 0, 0));
    vecs.push_back(mk(0, 0, 'h0,   0, 2, 3, 1, 1, 2, 'h4,   1, 0, 1));
    vecs.push_back(mk(0, 0, 'h0,   0, 2, 3, 1, 0, 0, 'h0,   0, 0, 0));
    // fill under hold, fifth refused
    vecs.push_back(mk(1, 1, 'h101, 1, 3, 7, 1, 0, 0, 'h0,   0, 0, 0));
    vecs.push_back(mk(1, 2, 'h102, 1, 3, 7, 1, 0, 1, 'h101, 0, 0, 1));
    vecs.push_back(mk(1, 3, 'h103, 1, 3, 7, 1, 0, 1, 'h101, 0, 0, 2));
    vecs.push_back(mk(1, 4, 'h104, 1, 3, 7, 1, 0, 1, 'h101, 1, 0, 3));
    vecs.push_back(mk(1, 5, 'h105, 1, 3, 7, 0, 0, 1, 'h101, 1, 0, 4));
    // release hold: drain in order
    vecs.push_back(mk(0, 0, 'h0,   0, 3, 5, 0, 1, 1, 'h101, 1, 0, 4));
    vecs.push_back(mk(0, 0, 'h0,   0, 3, 5, 1, 1, 2, 'h102, 1, 0, 3));
    vecs.push_back(mk(0, 0, 'h0,   0, 3, 5, 1, 1, 3, 'h103, 1, 0, 2));
    vecs.push_back(mk(0, 0, 'h0,   0, 3, 5, 1, 1, 4, 'h104, 0, 0, 1));
    vecs.push_back(mk(0, 0, 'h0,   0, 3, 5, 1, 0, 0, 'h0,   0, 0, 0));
    // duplicate destination, push and pop in the same cycle
    vecs.push_back(mk(1, 6, 'h10,  0, 6, 0, 1, 0, 0, 'h0,   0, 0, 0));
    vecs.push_back(mk(1, 6, 'h20,  0, 6, 0, 1, 1, 6, 'h10,  1, 0, 1));
    vecs.push_back(mk(0, 0, 'h0,   0, 6, 0, 1, 1, 6, 'h20,  1, 0, 1));
    vecs.push_back(mk(0, 0, 'h0,   0, 6, 0, 1, 0, 0, 'h0,   0, 0, 0));
    // register 0 behaves like any other
    vecs.push_back(mk(1, 0, 'h7,   1, 0, 6, 1, 0, 0, 'h0,   0, 0, 0));
    vecs.push_back(mk(0, 0, 'h0,   1, 0, 6, 1, 0, 0, 'h7,   1, 0, 1));
    vecs.push_back(mk(0, 0, 'h0,   0, 0, 6, 1, 1, 0, 'h7,   1, 0, 1));
    vecs.push_back(mk(0, 0, 'h0,   0, 0, 6, 1, 0, 0, 'h0,   0, 0, 0));

    reset = 1'b0;
    drive(1, 9, 'h55, 0, 9, 9);
    @(negedge clk);
    @(negedge clk);
    #1;
    expect_out("reset", 1, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      if (i > 0) @(negedge clk);
      drive(vecs[i].vld, vecs[i].res.rd, vecs[i].res.data, vecs[i].hold, vecs[i].q1, vecs[i].q2);
      if (i == 0) reset = 1'b1;
      #1;
      expect_out($sformatf("v%0d", i), vecs[i].rdy, vecs[i].we, vecs[i].a, vecs[i].wd,
                 vecs[i].p1, vecs[i].p2, vecs[i].cnt);
      if (i == 2) chk("rf2_first", 32'(rf[2]), 32'h4);
    end

    chk("rf1", 32'(rf[1]), 32'h101);
    chk("rf2", 32'(rf[2]), 32'h102);
    chk("rf3", 32'(rf[3]), 32'h103);
    chk("rf4", 32'(rf[4]), 32'h104);
    chk("rf5", 32'(rf[5]), 32'h0);
    chk("rf6", 32'(rf[6]), 32'h20);
    chk("rf0", 32'(rf[0]), 32'h7);

    // streaming push+pop across pointer wrap
    for (int i = 0; i <= 10; i++) begin
      @(negedge clk);
      drive(1, AW'(8 + i), DW'(32'h200 + i), 0, AW'(8 + i), 0);
      #1;
      if (i == 0) begin
        chk("stream0.count", 32'(count), 32'd0);
      end else begin
        chk($sformatf("stream%0d.count", i), 32'(count), 32'd1);
        chk($sformatf("stream%0d.we3", i),   32'(we3),   32'd1);
        chk($sformatf("stream%0d.a3", i),    32'(a3),    32'(7 + i));
        chk($sformatf("stream%0d.wd3", i),   32'(wd3),   32'h1ff + i);
        chk($sformatf("stream%0d.pend1", i), 32'(pend1), 32'd0);
      end
    end
    @(negedge clk);
    drive(0, 0, 0, 0, 18, 0);
    #1;
    expect_out("stream_tail", 1, 1, 18, 'h20a, 1, 0, 1);
    @(negedge clk);
    #1;
    expect_out("stream_empty", 1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i <= 10; i++)
      chk($sformatf("stream_rf%0d", 8 + i), 32'(rf[8 + i]), 32'h200 + i);

    // reset with three entries held
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive(1, AW'(20 + i), DW'(32'h300 + i), 1, 20, 0);
    end
    @(negedge clk);
    drive(0, 0, 0, 1, 20, 22);
    #1;
    chk("held.count", 32'(count), 32'd3);
    chk("held.pend1", 32'(pend1), 32'd1);
    chk("held.pend2", 32'(pend2), 32'd1);
    wc = wr_cnt;
    #2;
    hold_wb = 1'b0;
    reset   = 1'b0;
    #1;
    expect_out("rst_mid", 1, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      chk($sformatf("post_rst%0d.we3", i),   32'(we3),       32'd0);
      chk($sformatf("post_rst%0d.count", i), 32'(count),     32'd0);
      chk($sformatf("post_rst%0d.ready", i), 32'(res_ready), 32'd1);
    end
    chk("post_rst.writes", 32'(wr_cnt), 32'(wc));
    chk("post_rst.rf20",   32'(rf[20]), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/writeback_buffer.md
WRITEBACK_BUFFER -- requirements
Module: writeback_buffer

Interface
REQ-001 The block SHALL have parameter DATA_W, default 19, giving the register data width.
REQ-002 The block SHALL have parameter ADDR_W, default 5, giving the register number width.
REQ-003 The block SHALL have parameter DEPTH, default 4, giving the FIFO entry count (power of two, at least 2).
REQ-004 Port clk  input  1  is the single clock; all state SHALL update on its rising edge.
REQ-005 Port reset  input  1  is the asynchronous, active-low reset.
REQ-006 Port res_valid  input  1  SHALL indicate that a producer offers a result.
REQ-007 Port res_rd  input  ADDR_W  SHALL carry the destination register number.
REQ-008 Port res_data  input  DATA_W  SHALL carry the result value.
REQ-009 Port res_ready  output  1  SHALL indicate that the buffer accepts a result this cycle.
REQ-010 Port hold_wb  input  1  SHALL stall register-file writes while high.
REQ-011 Ports a3 (output, ADDR_W), we3 (output, 1) and wd3 (output, DATA_W) SHALL drive the register-file write port.
REQ-012 Ports q_a1 and q_a2 (input, ADDR_W each) SHALL carry the source register numbers under query.
REQ-013 Ports pend1 and pend2 (output, 1 each) SHALL flag a pending write to q_a1 and q_a2 respectively.
REQ-014 Port count  output  clog2(DEPTH)+1  SHALL report current FIFO occupancy.

Function
REQ-015 A push SHALL occur on a rising edge when res_valid and res_ready are both 1.
  - A push SHALL store {res_rd, res_data} at the tail.
REQ-016 res_ready SHALL equal (count != DEPTH).
  - It SHALL be combinational from state only, with no dependence on res_valid.
  - There SHALL be no same-cycle bypass when full: if full, no push occurs even when a pop happens that cycle.
REQ-017 we3 SHALL equal (count != 0) AND NOT hold_wb.
  - a3 and wd3 SHALL show the head entry whenever count != 0.
  - a3 and wd3 SHALL be 0 when the buffer is empty.
REQ-018 A pop SHALL occur on every rising edge where we3 = 1; exactly one entry SHALL be retired per edge.
REQ-019 Latency: a result pushed into an empty buffer at edge N SHALL present we3 = 1 in the cycle following edge N and SHALL be written at edge N+1 (hold_wb low).
REQ-020 Simultaneous push and pop SHALL leave count unchanged and SHALL preserve order.
REQ-021 Read and write pointers SHALL wrap modulo DEPTH.
  - count SHALL saturate at neither bound; overflow and underflow are impossible by REQ-016 and REQ-017.
REQ-022 Entries SHALL be written to the register file in strict arrival order, duplicates to the same register included.
REQ-023 pend1 SHALL be 1 iff some valid entry has rd == q_a1; pend2 likewise for q_a2.
  - Both SHALL be combinational.
  - The head entry SHALL count as pending even in the cycle it is being written.
REQ-024 Register number 0 SHALL receive no special treatment.
REQ-025 hold_wb SHALL NOT block pushes; with hold_wb high the buffer SHALL fill to DEPTH and then deassert res_ready.

Reset
REQ-026 While reset = 0, the following SHALL hold asynchronously:
  - count = 0, pointers = 0, all entries invalid;
  - we3 = 0, a3 = 0, wd3 = 0, pend1 = pend2 = 0;
  - res_ready = 1.
REQ-027 Reset asserted mid-operation SHALL discard all buffered entries; no write SHALL occur for them after release.
REQ-028 The first push SHALL be possible on the first rising edge after reset deasserts.

Structure
REQ-029 DATA_W/ADDR_W defaults and the entry struct type {rd, data} SHALL live in shared package wb_pkg.
REQ-030 Storage and pointers SHALL be a sub-module wb_fifo (push/pop/count/head), instantiated once.
  - wb_fifo SHALL expose per-entry valid flags and rd fields for the scoreboard compare.

Verification
REQ-031 The bench SHALL cover these directed scenarios:
  - Reset, then push rd=2, data=19'h4 -> next cycle we3=1, a3=2, wd3=19'h4; register file rd1 at a1=2 reads 19'h4 after the edge; count returns to 0.
  - hold_wb=1, push 5 results (rd 1..5) -> first 4 accepted, res_ready=0 on the 5th; count=4; pend1=1 for q_a1=3, pend2=0 for q_a2=7.
  - Release hold_wb -> writes rd 1,2,3,4 on 4 consecutive edges, in order.
  - Two pushes to rd=6 (19'h10 then 19'h20) -> reg 6 ends at 19'h20; pend for 6 stays 1 until the second write retires.
  - Continuous push plus pop for 10 cycles -> count stays 1, pointers wrap, no entry lost.
  - reset pulsed low with 3 entries buffered -> we3=0 immediately; no writes occur after release; res_ready=1.
